writeback: RTL and testbench
============================

// Module: writeback
// PURPOSE
//  Final pipeline stage, directly downstream of the execute stage. Consumes the
//  retiring instruction (opcode, destination, ALU result, PC) and commits it to
//  the 8-entry architectural register file. For ld it waits on memory read data.
//  For call/callr it writes the link address. Provides two bypassed read ports
//  to the register-read stage, plus a retired-instruction counter.
// PARAMETERS
//  DATA_W    16  datapath / register width
//  NREGS     8   architectural registers (address width = $clog2(NREGS))
//  LINK_REG  7   register written with the return address by call/callr
//  PC_STEP   2   link value = wb_pc + PC_STEP (byte-addressed 16-bit instrs)
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  wb_valid_in    in   1       instruction present on wb_* this cycle
//  wb_instr       in   5       opcode of retiring instruction
//  wb_rx          in   3       destination register index
//  wb_alu_r       in   DATA_W  ALU result latched by execute
//  wb_pc          in   DATA_W  PC of retiring instruction
//  i_mem_rdata    in   DATA_W  load data from memory
//  i_mem_rvalid   in   1       i_mem_rdata valid this cycle
//  wb_stall       out  1       high: upstream must hold; wb_* not accepted
//  rd_a_addr      in   3       read port A address
//  rd_b_addr      in   3       read port B address
//  rd_a_data      out  DATA_W  read port A data (combinational, bypassed)
//  rd_b_data      out  DATA_W  read port B data (combinational, bypassed)
//  o_wr_en        out  1       register write occurring this cycle
//  o_wr_addr      out  3       register being written
//  o_wr_data      out  DATA_W  value being written
//  o_retired      out  16      count of completed instructions, wraps
// BEHAVIOUR
//  Reset: all registers=0, state=RUN, o_retired=0, wb_stall=0, o_wr_en=0.
//  Opcode classes:
//   - ALU writes rx <- wb_alu_r: mv 00000, add 00001, sub 00010, mvi 10000,
//     addi 10001, subi 10010, mvhi 10110.
//   - Load: ld 00100 writes rx <- i_mem_rdata.
//   - Link: callr 01100, call 11100 write LINK_REG <- wb_pc+PC_STEP (mod 2^DATA_W).
//   - No write: cmp, cmpi, st, jr, jzr, jnr, j, jz, jn, and any undefined opcode.
//  Accept = wb_valid_in && !wb_stall. wb_stall = (state==WAIT_LD), from state only.
//  FSM RUN:
//   - Accept of non-ld: commit in the same cycle (o_wr_* valid that cycle,
//     register updated at the edge). Retire++.
//   - Accept of ld with i_mem_rvalid=1: commit the load data the same cycle. Retire++.
//   - Accept of ld with i_mem_rvalid=0: latch rx, go to WAIT_LD, no write.
//  FSM WAIT_LD:
//   - wb_* inputs are ignored.
//   - On i_mem_rvalid=1: write the latched rx <- i_mem_rdata, retire++, return
//     to RUN. The stage accepts new wb_* the next cycle, 1 bubble minimum.
//  i_mem_rvalid outside a pending ld is ignored.
//  Read ports: if o_wr_en and addr==o_wr_addr return o_wr_data, else the
//  register contents. Both ports may bypass simultaneously.
//  o_retired: +1 per completed instruction, including no-write ones;
//  0xFFFF -> 0x0000.
//  Reset in WAIT_LD: the pending load is dropped, no write, state=RUN.
// TESTING
//  1. reset; addi rx=3 alu_r=0x0012 valid -> o_wr_en=1, r3=0x0012 next cycle,
//     o_retired=1.
//  2. cmp valid alu_r=0xFFFF -> o_wr_en=0, regs unchanged, o_retired increments.
//  3. ld rx=5, rvalid=0 for 3 cycles then rdata=0xBEEF -> wb_stall=1 for those
//     3 cycles, r5=0xBEEF, wb_stall=0 the following cycle.
//  4. call wb_pc=0xFFFE -> r7=0x0000; callr wb_pc=0x0100 -> r7=0x0102.
//  5. mv rx=2 alu_r=0x00AA with rd_a_addr=rd_b_addr=2 same cycle -> both read
//     0x00AA.
//  6. reset asserted in WAIT_LD, then rvalid=1 -> no write, wb_stall=0.
//     Preload o_retired=0xFFFF, retire -> 0x0000.

Source files
------------

// File: rtl/writeback.sv
// writeback: final pipeline stage. Commits ALU results, load data and link
// addresses to an 8-entry register file. It also provides two bypassed read
// ports and a retired-instruction counter.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   wb_valid_in       retiring instruction present on wb_* this cycle
//   wb_instr          5-bit opcode of the retiring instruction
//   wb_rx             destination register index
//   wb_alu_r, wb_pc   ALU result and PC of the retiring instruction
//   i_mem_rdata       load data from memory
//   i_mem_rvalid      i_mem_rdata valid this cycle
//   wb_stall          high while a load waits for data; wb_* is not accepted
//   rd_a/b_addr       read port addresses
//   rd_a/b_data       read port data (combinational, bypassed from o_wr_*)
//   o_wr_en/addr/data register write taking effect at the next edge
//   o_retired         completed-instruction count (wraps)
module writeback #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 8,
    parameter int LINK_REG = 7,
    parameter int PC_STEP  = 2,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid_in,
    input  logic [4:0]        wb_instr,
    input  logic [AW-1:0]     wb_rx,
    input  logic [DATA_W-1:0] wb_alu_r,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_rvalid,
    output logic              wb_stall,
    input  logic [AW-1:0]     rd_a_addr,
    input  logic [AW-1:0]     rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              o_wr_en,
    output logic [AW-1:0]     o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [15:0]       o_retired
);

    localparam logic [AW-1:0]     LINK_A = AW'(LINK_REG);
    localparam logic [DATA_W-1:0] STEP   = DATA_W'(PC_STEP);

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_LD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [AW-1:0]       ld_rx;
    logic                is_alu;
    logic                is_ld;
    logic                is_link;
    logic                accept;
    logic                retire;
    logic                latch_ld;

    assign wb_stall = (state == WAIT_LD);
    assign accept   = wb_valid_in && !wb_stall;

    // Opcode classes; everything not listed retires without a write.
    always_comb begin
        is_alu  = 1'b0;
        is_ld   = 1'b0;
        is_link = 1'b0;
        case (wb_instr)
            5'b00000, 5'b00001, 5'b00010,
            5'b10000, 5'b10001, 5'b10010,
            5'b10110:          is_alu  = 1'b1;
            5'b00100:          is_ld   = 1'b1;
            5'b01100, 5'b11100: is_link = 1'b1;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            RUN:     if (accept && is_ld && !i_mem_rvalid) state_d = WAIT_LD;
            WAIT_LD: if (i_mem_rvalid)                     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output logic. Reset suppresses any commit in its own cycle, so a
    // pending load caught by reset is simply dropped.
    always_comb begin
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        retire    = 1'b0;
        latch_ld  = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (is_ld && !i_mem_rvalid) begin
                            latch_ld = 1'b1;
                        end else begin
                            retire = 1'b1;
                            if (is_ld) begin
                                o_wr_en   = 1'b1;
                                o_wr_addr = wb_rx;
                                o_wr_data = i_mem_rdata;
                            end else if (is_alu) begin
                                o_wr_en   = 1'b1;
                                o_wr_addr = wb_rx;
                                o_wr_data = wb_alu_r;
                            end else if (is_link) begin
                                o_wr_en   = 1'b1;
                                o_wr_addr = LINK_A;
                                o_wr_data = wb_pc + STEP;
                            end
                        end
                    end
                end
                WAIT_LD: begin
                    if (i_mem_rvalid) begin
                        retire    = 1'b1;
                        o_wr_en   = 1'b1;
                        o_wr_addr = ld_rx;
                        o_wr_data = i_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs      <= '{default: '0};
            ld_rx     <= '0;
            o_retired <= '0;
        end else begin
            if (o_wr_en)  regs[o_wr_addr] <= o_wr_data;
            if (latch_ld) ld_rx <= wb_rx;
            if (retire)   o_retired <= o_retired + 16'd1;
        end
    end

    // Read ports see the write happening this cycle.
    assign rd_a_data = (o_wr_en && rd_a_addr == o_wr_addr) ? o_wr_data
                                                          : regs[rd_a_addr];
    assign rd_b_data = (o_wr_en && rd_b_addr == o_wr_addr) ? o_wr_data
                                                          : regs[rd_b_addr];

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: vector table, hand sequences for load wait / reset / wrap,
// and randomized traffic against an instruction-level reference model.
module tb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid_in;
    logic [4:0]  wb_instr;
    logic [2:0]  wb_rx;
    logic [15:0] wb_alu_r;
    logic [15:0] wb_pc;
    logic [15:0] i_mem_rdata;
    logic        i_mem_rvalid;
    logic        wb_stall;
    logic [2:0]  rd_a_addr;
    logic [2:0]  rd_b_addr;
    logic [15:0] rd_a_data;
    logic [15:0] rd_b_data;
    logic        o_wr_en;
    logic [2:0]  o_wr_addr;
    logic [15:0] o_wr_data;
    logic [15:0] o_retired;

    writeback dut (
        .clk(clk), .reset(reset),
        .wb_valid_in(wb_valid_in), .wb_instr(wb_instr), .wb_rx(wb_rx),
        .wb_alu_r(wb_alu_r), .wb_pc(wb_pc),
        .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid),
        .wb_stall(wb_stall),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: architectural state at instruction granularity.
    logic [15:0] m_regs [8];
    logic [15:0] m_ret;
    logic        m_pend;
    logic [2:0]  m_prx;

    typedef struct {
        logic v; logic [4:0] op; logic [2:0] rx;
        logic [15:0] alu; logic [15:0] pc; logic [15:0] rdata; logic rv;
        logic [2:0] ra; logic [2:0] rb;
        logic we; logic [2:0] wa; logic [15:0] wd;
        logic [15:0] ea; logic [15:0] eb; logic [15:0] eret;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // 0 none, 1 writes rx from ALU, 2 load, 3 link
    function automatic int opclass(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00001, 5'b00010, 5'b10000,
            5'b10001, 5'b10010, 5'b10110: return 1;
            5'b00100: return 2;
            5'b01100, 5'b11100: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic predict(output logic we, output logic [2:0] wa,
                           output logic [15:0] wd);
        int c;
        we = 1'b0; wa = '0; wd = '0;
        c = opclass(wb_instr);
        if (reset) begin
            we = 1'b0;
        end else if (m_pend) begin
            if (i_mem_rvalid) begin
                we = 1'b1; wa = m_prx; wd = i_mem_rdata;
            end
        end else if (wb_valid_in) begin
            if (c == 1) begin
                we = 1'b1; wa = wb_rx; wd = wb_alu_r;
            end else if (c == 2 && i_mem_rvalid) begin
                we = 1'b1; wa = wb_rx; wd = i_mem_rdata;
            end else if (c == 3) begin
                we = 1'b1; wa = 3'd7; wd = 16'(wb_pc + 16'd2);
            end
        end
    endtask

    task automatic model_commit();
        logic we; logic [2:0] wa; logic [15:0] wd;
        predict(we, wa, wd);
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_ret  = '0;
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (i_mem_rvalid) begin
                m_regs[wa] = wd;
                m_ret++;
                m_pend = 1'b0;
            end
        end else if (wb_valid_in) begin
            if (opclass(wb_instr) == 2 && !i_mem_rvalid) begin
                m_pend = 1'b1;
                m_prx  = wb_rx;
            end else begin
                if (we) m_regs[wa] = wd;
                m_ret++;
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic we; logic [2:0] wa; logic [15:0] wd;
        logic [15:0] ea, eb;
        predict(we, wa, wd);
        ea = (we && rd_a_addr == wa) ? wd : m_regs[rd_a_addr];
        eb = (we && rd_b_addr == wa) ? wd : m_regs[rd_b_addr];
        chk({tag, ".stall"}, 16'(wb_stall), 16'(m_pend));
        chk({tag, ".we"}, 16'(o_wr_en), 16'(we));
        if (we) begin
            chk({tag, ".wa"}, 16'(o_wr_addr), 16'(wa));
            chk({tag, ".wd"}, o_wr_data, wd);
        end
        chk({tag, ".rda"}, rd_a_data, ea);
        chk({tag, ".rdb"}, rd_b_data, eb);
        chk({tag, ".ret"}, o_retired, m_ret);
    endtask

    task automatic drive(input logic v, input logic [4:0] op,
                         input logic [2:0] rx, input logic [15:0] alu,
                         input logic [15:0] pc, input logic [15:0] rdata,
                         input logic rv, input logic [2:0] ra,
                         input logic [2:0] rb);
        wb_valid_in = v; wb_instr = op; wb_rx = rx;
        wb_alu_r = alu; wb_pc = pc;
        i_mem_rdata = rdata; i_mem_rvalid = rv;
        rd_a_addr = ra; rd_b_addr = rb;
    endtask

    task automatic next_cycle();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b10000,
                             5'b10001, 5'b10010, 5'b10110, 5'b00100,
                             5'b00100, 5'b01100, 5'b11100, 5'b00011};

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_ret = '0; m_pend = 1'b0; m_prx = '0;

        tbl[0] = '{1'b1, 5'b10001, 3'd3, 16'h0012, 16'h0000, 16'h0000, 1'b0,
                   3'd3, 3'd0, 1'b1, 3'd3, 16'h0012, 16'h0012, 16'h0000, 16'd0};
        tbl[1] = '{1'b1, 5'b00011, 3'd3, 16'hFFFF, 16'h0000, 16'h0000, 1'b0,
                   3'd3, 3'd1, 1'b0, 3'd0, 16'h0000, 16'h0012, 16'h0000, 16'd1};
        tbl[2] = '{1'b1, 5'b00000, 3'd2, 16'h00AA, 16'h0000, 16'h0000, 1'b0,
                   3'd2, 3'd2, 1'b1, 3'd2, 16'h00AA, 16'h00AA, 16'h00AA, 16'd2};
        tbl[3] = '{1'b1, 5'b11100, 3'd0, 16'h0000, 16'hFFFE, 16'h0000, 1'b0,
                   3'd7, 3'd3, 1'b1, 3'd7, 16'h0000, 16'h0000, 16'h0012, 16'd3};
        tbl[4] = '{1'b1, 5'b01100, 3'd0, 16'h0000, 16'h0100, 16'h0000, 1'b0,
                   3'd7, 3'd2, 1'b1, 3'd7, 16'h0102, 16'h0102, 16'h00AA, 16'd4};
        tbl[5] = '{1'b0, 5'b00001, 3'd1, 16'h5555, 16'h0000, 16'h0000, 1'b0,
                   3'd1, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0102, 16'd5};
        tbl[6] = '{1'b1, 5'b00100, 3'd4, 16'h9999, 16'h0000, 16'h1234, 1'b1,
                   3'd4, 3'd2, 1'b1, 3'd4, 16'h1234, 16'h1234, 16'h00AA, 16'd5};
        tbl[7] = '{1'b1, 5'b00010, 3'd1, 16'h7777, 16'h0000, 16'h1111, 1'b1,
                   3'd1, 3'd4, 1'b1, 3'd1, 16'h7777, 16'h7777, 16'h1234, 16'd6};
        tbl[8] = '{1'b1, 5'b11111, 3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                   3'd2, 3'd1, 1'b0, 3'd0, 16'h0000, 16'h00AA, 16'h7777, 16'd7};

        // Reset
        reset = 1'b1;
        drive(1'b0, 5'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd3, 3'd7);
        @(posedge clk); #1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rst.ret", o_retired, 16'h0000);
        chk("rst.stall", 16'(wb_stall), 16'h0);
        chk("rst.we", 16'(o_wr_en), 16'h0);
        chk("rst.r3", rd_a_data, 16'h0000);
        chk("rst.r7", rd_b_data, 16'h0000);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].rx, tbl[i].alu, tbl[i].pc,
                  tbl[i].rdata, tbl[i].rv, tbl[i].ra, tbl[i].rb);
            #1;
            chk($sformatf("tbl%0d.we", i), 16'(o_wr_en), 16'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d.wa", i), 16'(o_wr_addr),
                    16'(tbl[i].wa));
                chk($sformatf("tbl%0d.wd", i), o_wr_data, tbl[i].wd);
            end
            chk($sformatf("tbl%0d.rda", i), rd_a_data, tbl[i].ea);
            chk($sformatf("tbl%0d.rdb", i), rd_b_data, tbl[i].eb);
            chk($sformatf("tbl%0d.stall", i), 16'(wb_stall), 16'h0);
            chk($sformatf("tbl%0d.ret", i), o_retired, tbl[i].eret);
            next_cycle();
        end

        // Load waiting three cycles for data
        drive(1'b1, 5'b00100, 3'd5, 16'h4444, 16'h0, 16'h0, 1'b0, 3'd5, 3'd1);
        #1;
        chk("ld.acc.we", 16'(o_wr_en), 16'h0);
        chk("ld.acc.stall", 16'(wb_stall), 16'h0);
        chk("ld.acc.ret", o_retired, 16'd8);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b10001, 3'd1, 16'hDEAD, 16'h0, 16'h0, 1'b0,
                  3'd5, 3'd1);
            #1;
            chk($sformatf("ld.wait%0d.stall", i), 16'(wb_stall), 16'h1);
            chk($sformatf("ld.wait%0d.we", i), 16'(o_wr_en), 16'h0);
            next_cycle();
        end
        drive(1'b1, 5'b10001, 3'd1, 16'hDEAD, 16'h0, 16'hBEEF, 1'b1,
              3'd5, 3'd1);
        #1;
        chk("ld.data.we", 16'(o_wr_en), 16'h1);
        chk("ld.data.wa", 16'(o_wr_addr), 16'd5);
        chk("ld.data.wd", o_wr_data, 16'hBEEF);
        next_cycle();
        drive(1'b0, 5'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd5, 3'd1);
        #1;
        chk("ld.after.stall", 16'(wb_stall), 16'h0);
        chk("ld.after.r5", rd_a_data, 16'hBEEF);
        chk("ld.after.r1", rd_b_data, 16'h7777);
        chk("ld.after.ret", o_retired, 16'd9);
        next_cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int k;
            reset = ($urandom_range(0, 63) == 0);
            k = $urandom_range(0, 15);
            drive(($urandom_range(0, 3) != 0),
                  (k < 12) ? ops[k] : 5'($urandom),
                  3'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), ($urandom_range(0, 2) == 0),
                  3'($urandom), 3'($urandom));
            #1;
            model_check($sformatf("rnd%0d", i));
            next_cycle();
        end
        reset = 1'b0;

        // Reset while a load is pending
        drive(1'b1, 5'b00100, 3'd6, 16'h0, 16'h0, 16'h0, 1'b0, 3'd6, 3'd6);
        #1;
        next_cycle();
        drive(1'b1, 5'b00100, 3'd6, 16'h0, 16'h0, 16'h0, 1'b0, 3'd6, 3'd6);
        #1;
        chk("rstld.pend.stall", 16'(wb_stall), 16'h1);
        reset = 1'b1;
        drive(1'b0, 5'd0, 3'd0, 16'h0, 16'h0, 16'hDEAD, 1'b1, 3'd6, 3'd6);
        #1;
        chk("rstld.rst.we", 16'(o_wr_en), 16'h0);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rstld.post.stall", 16'(wb_stall), 16'h0);
        chk("rstld.post.we", 16'(o_wr_en), 16'h0);
        chk("rstld.post.r6", rd_a_data, 16'h0000);
        chk("rstld.post.ret", o_retired, 16'h0000);
        next_cycle();
        drive(1'b0, 5'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd6, 3'd6);
        #1;
        chk("rstld.late.r6", rd_a_data, 16'h0000);

        // Retired counter wrap
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 5'b00011, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0,
                  3'd0, 3'd0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd0);
        #1;
        chk("wrap.ffff", o_retired, 16'hFFFF);
        chk("wrap.model", o_retired, m_ret);
        drive(1'b1, 5'b00011, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd0);
        next_cycle();
        drive(1'b0, 5'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd0);
        #1;
        chk("wrap.zero", o_retired, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
